// File: rtl/rsa_word_bridge.sv
// Purpose : packs 32-bit ARM words into a 1024-bit RSA operand and serialises a
//           1024-bit RSA result back out as 32-bit words with a last flag.
// Latency : wide_valid 1 cycle after the final inbound beat; first outbound beat
//           1 cycle after the result is captured.
// Backpressure: single buffer per path. Inbound stalls (s_word_ready=0) while the
//           packed operand waits for wide_ready. res_ready stays low until the
//           last outbound beat is accepted.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   s_word_data/valid/last/ready      inbound 32-bit beats (last used only with
//                                     BRIDGE_SHORT_FRAME_EN)
//   wide_data/valid/ready             packed operand towards the RSA wrapper
//   res_data/valid/ready              wide result from the RSA wrapper
//   m_word_data/valid/last/ready      outbound 32-bit beats
//   busy                              either path is mid-frame
//
// Optional feature macro: BRIDGE_SHORT_FRAME_EN
//   When defined, an inbound beat with s_word_last=1 closes the frame early and
//   the unwritten upper words of the operand read as zero.

module rsa_word_bridge #(
   parameter int WIDE_W = 1024,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   // inbound narrow beats
   input  logic [WORD_W-1:0] s_word_data,
   input  logic              s_word_valid,
   input  logic              s_word_last,
   output logic              s_word_ready,
   // packed operand
   output logic [WIDE_W-1:0] wide_data,
   output logic              wide_valid,
   input  logic              wide_ready,
   // wide result
   input  logic [WIDE_W-1:0] res_data,
   input  logic              res_valid,
   output logic              res_ready,
   // outbound narrow beats
   output logic [WORD_W-1:0] m_word_data,
   output logic              m_word_valid,
   output logic              m_word_last,
   input  logic              m_word_ready,
   // status
   output logic              busy
);

   localparam int N_WORDS = WIDE_W / WORD_W;
   localparam int CNT_W   = $clog2(N_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      P_FILL = 1'b0,
      P_HOLD = 1'b1
   } pk_state_t;

   typedef enum logic {
      U_IDLE = 1'b0,
      U_SEND = 1'b1
   } up_state_t;

   // ---------------------------------------------------------------------------
   // Packer state
   // ---------------------------------------------------------------------------
   pk_state_t         pk_state_q, pk_state_d;
   logic [CNT_W-1:0]  in_cnt_q,   in_cnt_d;
   logic [WIDE_W-1:0] pbuf_q,     pbuf_d;

   // ---------------------------------------------------------------------------
   // Unpacker state
   // ---------------------------------------------------------------------------
   up_state_t         up_state_q, up_state_d;
   logic [CNT_W-1:0]  out_cnt_q,  out_cnt_d;
   logic [WIDE_W-1:0] sreg_q,     sreg_d;

   // Frame end condition for the packer.
   logic frame_end;

`ifdef BRIDGE_SHORT_FRAME_EN
   // A terminator on any beat closes the frame; on the final slot it is a
   // normal full frame anyway.
   assign frame_end = (in_cnt_q == LAST_IDX) || s_word_last;
`else
   // Frames are always exactly N_WORDS beats; the terminator is ignored.
   logic unused_s_word_last;
   assign unused_s_word_last = s_word_last;
   assign frame_end = (in_cnt_q == LAST_IDX);
`endif

   // ---------------------------------------------------------------------------
   // Packer next-state / outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      pk_state_d   = pk_state_q;
      in_cnt_d     = in_cnt_q;
      pbuf_d       = pbuf_q;
      s_word_ready = 1'b0;
      wide_valid   = 1'b0;

      case (pk_state_q)
         P_FILL: begin
            s_word_ready = 1'b1;
            if (s_word_valid) begin
               // Beat 0 lands in the least significant word.
               pbuf_d[int'(in_cnt_q) * WORD_W +: WORD_W] = s_word_data;
               if (frame_end) begin
                  in_cnt_d   = '0;
                  pk_state_d = P_HOLD;
               end else begin
                  in_cnt_d = in_cnt_q + CNT_ONE;
               end
            end
         end
         P_HOLD: begin
            wide_valid = 1'b1;
            if (wide_ready) begin
               // Clearing here is what makes short-frame upper words read 0.
               pbuf_d     = '0;
               pk_state_d = P_FILL;
            end
         end
         default: begin
            pk_state_d = P_FILL;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Unpacker next-state / outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      up_state_d   = up_state_q;
      out_cnt_d    = out_cnt_q;
      sreg_d       = sreg_q;
      res_ready    = 1'b0;
      m_word_valid = 1'b0;
      m_word_last  = 1'b0;

      case (up_state_q)
         U_IDLE: begin
            res_ready = 1'b1;
            if (res_valid) begin
               sreg_d     = res_data;
               out_cnt_d  = '0;
               up_state_d = U_SEND;
            end
         end
         U_SEND: begin
            m_word_valid = 1'b1;
            m_word_last  = (out_cnt_q == LAST_IDX);
            if (m_word_ready) begin
               // Zero-fill shift: after the last beat sreg is all zero, so the
               // data output idles at 0 between frames.
               sreg_d = sreg_q >> WORD_W;
               if (out_cnt_q == LAST_IDX) begin
                  out_cnt_d  = '0;
                  up_state_d = U_IDLE;
               end else begin
                  out_cnt_d = out_cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            up_state_d = U_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pk_state_q <= P_FILL;
         in_cnt_q   <= '0;
         pbuf_q     <= '0;
      end else begin
         pk_state_q <= pk_state_d;
         in_cnt_q   <= in_cnt_d;
         pbuf_q     <= pbuf_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         up_state_q <= U_IDLE;
         out_cnt_q  <= '0;
         sreg_q     <= '0;
      end else begin
         up_state_q <= up_state_d;
         out_cnt_q  <= out_cnt_d;
         sreg_q     <= sreg_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath outputs and status
   // ---------------------------------------------------------------------------
   assign wide_data   = pbuf_q;
   assign m_word_data = sreg_q[WORD_W-1:0];
   assign busy        = (in_cnt_q != '0) || (pk_state_q == P_HOLD) ||
                        (up_state_q == U_SEND);

endmodule

// File: doc/rsa_word_bridge.md
Name: rsa_word_bridge

Overview:
- Sits between the ARM-side 32-bit word interface and the 1024-bit operand/result ports of the RSA command wrapper.
- Inbound path: packs N_WORDS consecutive 32-bit words into one wide operand and presents it on a valid/ready handshake. That output drives the wrapper's arm_to_fpga_data/valid/ready.
- Outbound path: captures one wide result from the wrapper's fpga_to_arm_data/valid/ready and serialises it as 32-bit words with a last flag.
- The two paths are independent and may run concurrently.

Parameters:
- WIDE_W, 1024, width of operand/result word; must be an integer multiple of WORD_W.
- WORD_W, 32, width of narrow beat.
- N_WORDS, WIDE_W/WORD_W (32), beats per frame; derived, not overridable.
- CNT_W, clog2(N_WORDS) (5), beat counter width; derived.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  reset; asynchronous assert, active-low.
- s_word_data  in  WORD_W  inbound beat.
- s_word_valid  in  1  inbound beat valid.
- s_word_last  in  1  inbound frame terminator (used only with the optional feature).
- s_word_ready  out  1  bridge accepts inbound beat.
- wide_data  out  WIDE_W  packed operand to wrapper.
- wide_valid  out  1  packed operand valid.
- wide_ready  in  1  wrapper accepts operand.
- res_data  in  WIDE_W  result from wrapper.
- res_valid  in  1  result valid.
- res_ready  out  1  bridge accepts result.
- m_word_data  out  WORD_W  outbound beat.
- m_word_valid  out  1  outbound beat valid.
- m_word_last  out  1  final beat of outbound frame.
- m_word_ready  in  1  consumer accepts outbound beat.
- busy  out  1  either path mid-frame (packer count nonzero, packer HOLD, or unpacker SEND).

Behaviour:
- Handshake rule: a transfer occurs on any rising edge where valid and ready are both 1. Valid never depends combinationally on ready. Data and valid stay stable until the transfer.
- Reset (asynchronous, resetn=0):
  - Packer state FILL, unpacker state IDLE, both counters 0, both buffers 0.
  - Outputs: s_word_ready=1, res_ready=1, wide_valid=0, m_word_valid=0, m_word_last=0, wide_data=0, m_word_data=0, busy=0.
  - Reset asserted mid-frame discards partial data. No state survives.
- Packer FSM, states FILL and HOLD:
  - FILL: s_word_ready=1, wide_valid=0. On each beat transfer, write buf[in_cnt*WORD_W +: WORD_W] = s_word_data and increment in_cnt. Beat 0 is least significant.
  - FILL to HOLD: on the transfer where in_cnt==N_WORDS-1. in_cnt wraps to 0. wide_valid=1 on the following cycle (1-cycle latency after the last beat).
  - HOLD: s_word_ready=0, wide_data=buf, held stable.
  - HOLD to FILL: on wide transfer. The buffer is cleared to 0 on that same edge.
  - No double buffering: beats offered during HOLD are stalled, never dropped.
- Unpacker FSM, states IDLE and SEND:
  - IDLE: res_ready=1. On res transfer, capture res_data into sreg, set out_cnt=0, go to SEND.
  - SEND: res_ready=0, m_word_valid=1, m_word_data=sreg[WORD_W-1:0], m_word_last=(out_cnt==N_WORDS-1).
  - On each beat transfer: shift sreg right by WORD_W (zero-fill) and increment out_cnt.
  - On the transfer with m_word_last=1, go to IDLE. res_ready returns to 1 the next cycle.
  - m_word_ready held low stalls indefinitely with no state change.
- Simultaneous events: an inbound beat and an outbound beat in the same cycle are both honoured. A wide transfer and the final beat of the next frame cannot coincide, because HOLD blocks beats.
- Counters are exactly CNT_W bits. Wrap from N_WORDS-1 to 0 occurs only on the frame-final transfer.

Optional Feature:
- Macro BRIDGE_SHORT_FRAME_EN.
- Defined:
  - An inbound transfer with s_word_last=1 ends the frame immediately: go to HOLD, in_cnt resets to 0.
  - Unwritten upper words read as 0, since the buffer is cleared on entry to FILL. This allows short operands such as a small exponent e.
  - s_word_last on beat N_WORDS-1 behaves as a normal full frame.
- Not defined: s_word_last is ignored and every frame is exactly N_WORDS beats.

Test Plan:
- Full pack: push beats 0x00000000..0x0000001F with wide_ready=1 → wide_valid rises 1 cycle after beat 31. wide_data[31:0]=0x0, wide_data[1023:992]=0x1F. Transfer completes and s_word_ready=1 again.
- Backpressure: wide_ready=0 for 10 cycles after a full frame, while offering 0xDEADBEEF → s_word_ready=0, wide_data stable, the beat is not consumed until after the wide transfer.
- Unpack: res_data={32{0xA5A5A5A5}} except word0=0x1 and word31=0xF0F0F0F0 → 32 beats, first 0x1, last 0xF0F0F0F0 with m_word_last=1 on beat 31 only. res_ready low throughout SEND.
- Outbound stall: toggle m_word_ready every other cycle → beat order and values unchanged, exactly 32 transfers.
- Reset mid-frame: assert resetn=0 after 7 inbound beats and 5 outbound beats → all outputs return to reset values asynchronously. A subsequent full 32-beat frame packs correctly with no residue.
- BRIDGE_SHORT_FRAME_EN: 3 beats 0x11, 0x22, 0x33, with last on the third → wide_data=0x...0000003300000022_00000011, upper 29 words zero. Without the macro, the same stimulus leaves wide_valid=0.
